// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the 7-segment scan controller: segment patterns
// (bit6=a ... bit0=g, active high) and the scan FSM state encoding.
package seg_scan_ctrl_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

endpackage

// File: rtl/seg_scan_ctrl_decode.sv
// Combinational BCD-to-segment map; non-decimal codes 10..15 render as a
// blank digit rather than garbage.
module bcd_seg_decode
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-cathode 7-segment display,
// with blanking gaps between digits and frame-synchronous double buffering.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 1000,
    parameter int BLANK_CYCLES = 2
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(SLOT_CYCLES);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int DW    = 4 * NUM_DIGITS;
    localparam logic [NUM_DIGITS-1:0] SEL_ONE = NUM_DIGITS'(1);

    logic [1:0]       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [IDX_W-1:0] idx, idx_nx;
    logic             boundary;
    logic             wrap;

    logic [DW-1:0]         shadow_digits, active_digits;
    logic [NUM_DIGITS-1:0] shadow_dp, active_dp;
    logic                  pending;

    logic [3:0] cur_code;
    logic [6:0] dec_seg;

    // The slot counter runs across the whole slot; the first BLANK_CYCLES
    // counts are the dark gap, the remainder is the lit portion.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        boundary = 1'b0;
        wrap     = 1'b0;
        if (!enable) begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
            idx_nx   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nx = ST_BLANK;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                    boundary = 1'b1;
                end
                ST_BLANK: begin
                    cnt_nx = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(BLANK_CYCLES - 1))
                        state_nx = ST_SHOW;
                end
                ST_SHOW: begin
                    if (cnt == CNT_W'(SLOT_CYCLES - 1)) begin
                        cnt_nx   = '0;
                        state_nx = ST_BLANK;
                        if (idx == IDX_W'(NUM_DIGITS - 1)) begin
                            idx_nx   = '0;
                            wrap     = 1'b1;
                            boundary = 1'b1;
                        end else begin
                            idx_nx = idx + IDX_W'(1);
                        end
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
        end
    end

    // A load landing on a frame boundary bypasses the shadow so it is not
    // held back a whole extra frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_digits <= '0;
            shadow_dp     <= '0;
            active_digits <= '0;
            active_dp     <= '0;
            pending       <= 1'b0;
        end else begin
            if (load) begin
                shadow_digits <= digits_in;
                shadow_dp     <= dp_in;
            end
            if (boundary) begin
                pending <= 1'b0;
                if (load) begin
                    active_digits <= digits_in;
                    active_dp     <= dp_in;
                end else if (pending) begin
                    active_digits <= shadow_digits;
                    active_dp     <= shadow_dp;
                end
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    assign cur_code = active_digits[{idx_nx, 2'b00} +: 4];

    bcd_seg_decode u_decode (
        .code (cur_code),
        .seg  (dec_seg)
    );

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out    <= '0;
            dp_out     <= 1'b0;
            digit_sel  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (state_nx == ST_SHOW) begin
                digit_sel <= SEL_ONE << idx_nx;
                seg_out   <= dec_seg;
                dp_out    <= active_dp[idx_nx];
            end else begin
                digit_sel <= '0;
                seg_out   <= '0;
                dp_out    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios plus random
// traffic, compared every cycle against a scan-position reference model.
module tb_seg_scan_ctrl;

    localparam int N  = 4;
    localparam int S  = 40;
    localparam int B  = 2;
    localparam int FP = N * S;
    localparam int DW = 4 * N;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          load;
    logic [DW-1:0] digits_in;
    logic [N-1:0]  dp_in;
    logic [6:0]    seg_out;
    logic          dp_out;
    logic [N-1:0]  digit_sel;
    logic          frame_done;

    int vectors;
    int miscompares;

    logic [6:0] seg_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011, 7'b0000000, 7'b0000000,
                                 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};

    // Reference model: scan position t counts cycles since the scan started.
    bit         running;
    int         t;
    bit         pend;
    logic [3:0] act [N];
    logic [3:0] shd [N];
    bit         actdp [N];
    bit         shddp [N];

    seg_scan_ctrl #(
        .NUM_DIGITS   (N),
        .SLOT_CYCLES  (S),
        .BLANK_CYCLES (B)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic modelReset();
        running = 1'b0;
        t       = 0;
        pend    = 1'b0;
        for (int k = 0; k < N; k++) begin
            act[k] = 4'd0; shd[k] = 4'd0; actdp[k] = 1'b0; shddp[k] = 1'b0;
        end
    endtask

    task automatic modelStep(input bit en, input bit ld, input logic [DW-1:0] d,
                             input logic [N-1:0] dp);
        bit bnd;
        bnd = 1'b0;
        if (!en) begin
            running = 1'b0;
            t       = 0;
        end else if (!running) begin
            running = 1'b1;
            t       = 0;
            bnd     = 1'b1;
        end else begin
            t   = t + 1;
            bnd = (t % FP == 0);
        end
        if (bnd) begin
            for (int k = 0; k < N; k++) begin
                if (ld) begin
                    act[k] = d[4*k +: 4]; actdp[k] = dp[k];
                end else if (pend) begin
                    act[k] = shd[k]; actdp[k] = shddp[k];
                end
            end
            pend = 1'b0;
        end else if (ld) begin
            pend = 1'b1;
        end
        if (ld) begin
            for (int k = 0; k < N; k++) begin
                shd[k] = d[4*k +: 4]; shddp[k] = dp[k];
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [N-1:0] exp_sel;
        logic [6:0]   exp_seg;
        logic         exp_dp;
        logic         exp_fd;
        int           slot;
        int           off;
        exp_sel = '0; exp_seg = '0; exp_dp = 1'b0; exp_fd = 1'b0;
        slot = (t / S) % N;
        off  = t % S;
        if (running) begin
            exp_fd = (t != 0) && (t % FP == 0);
            if (off >= B) begin
                exp_sel[slot] = 1'b1;
                exp_seg       = seg_tab[act[slot]];
                exp_dp        = actdp[slot];
            end
        end
        vectors++;
        assert (digit_sel === exp_sel) else begin
            miscompares++;
            $error("[TB] FAIL %s digit_sel: observed %b expected %b (t=%0d)", tag, digit_sel, exp_sel, t);
        end
        vectors++;
        assert (seg_out === exp_seg) else begin
            miscompares++;
            $error("[TB] FAIL %s seg_out: observed %b expected %b (t=%0d)", tag, seg_out, exp_seg, t);
        end
        vectors++;
        assert (dp_out === exp_dp) else begin
            miscompares++;
            $error("[TB] FAIL %s dp_out: observed %b expected %b (t=%0d)", tag, dp_out, exp_dp, t);
        end
        vectors++;
        assert (frame_done === exp_fd) else begin
            miscompares++;
            $error("[TB] FAIL %s frame_done: observed %b expected %b (t=%0d)", tag, frame_done, exp_fd, t);
        end
    endtask

    task automatic applyStimulus(input bit en, input bit ld, input logic [DW-1:0] d,
                                 input logic [N-1:0] dp, input string tag);
        enable    = en;
        load      = ld;
        digits_in = d;
        dp_in     = dp;
        @(posedge clk);
        modelStep(en, ld, d, dp);
        #1;
        checkOutput(tag);
    endtask

    task automatic runCycles(input int n, input bit en, input string tag);
        for (int i = 0; i < n; i++)
            applyStimulus(en, 1'b0, digits_in, dp_in, tag);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        enable      = 1'b0;
        load        = 1'b0;
        digits_in   = '0;
        dp_in       = '0;
        rst_n       = 1'b1;
        modelReset();

        #2 rst_n = 1'b0;
        #2 checkOutput("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        runCycles(30, 1'b0, "disabled_dark");

        $display("[TB] load 1234 while idle, then enable");
        applyStimulus(1'b0, 1'b1, 16'h1234, 4'b0010, "load_1234");
        runCycles(2 * FP + 5, 1'b1, "scan_1234");

        $display("[TB] invalid codes render blank");
        applyStimulus(1'b1, 1'b1, 16'hFA09, 4'b1001, "load_fa09");
        runCycles(2 * FP, 1'b1, "scan_fa09");

        $display("[TB] two mid-frame loads, last wins at boundary");
        while ((t % FP) != S + 7) runCycles(1, 1'b1, "seek_mid");
        applyStimulus(1'b1, 1'b1, 16'h5678, 4'b0101, "load_5678");
        runCycles(20, 1'b1, "mid_frame");
        applyStimulus(1'b1, 1'b1, 16'h9999, 4'b0000, "load_9999");
        runCycles(2 * FP, 1'b1, "scan_9999");

        $display("[TB] load coincident with frame boundary");
        while (((t + 1) % FP) != 0) runCycles(1, 1'b1, "seek_boundary");
        applyStimulus(1'b1, 1'b1, 16'h4321, 4'b1000, "load_on_boundary");
        runCycles(2 * FP, 1'b1, "scan_4321");

        $display("[TB] drop enable during digit 2 show");
        while (!(((t / S) % N) == 2 && (t % S) >= B + 3)) runCycles(1, 1'b1, "seek_digit2");
        runCycles(10, 1'b0, "enable_dropped");
        runCycles(FP + 10, 1'b1, "reenabled");

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            bit            en;
            bit            ld;
            logic [DW-1:0] d;
            logic [N-1:0]  dp;
            en = ($urandom_range(0, 199) != 0);
            ld = ($urandom_range(0, 99) < 3);
            d  = DW'($urandom);
            dp = N'($urandom);
            applyStimulus(en, ld, d, dp, "random");
        end

        $display("[TB] reset asserted mid-show");
        applyStimulus(1'b1, 1'b1, 16'h7777, 4'b1111, "pre_reset_load");
        while ((t % S) != B + 5) runCycles(1, 1'b1, "seek_show");
        rst_n = 1'b0;
        #3;
        modelReset();
        checkOutput("async_reset");
        @(posedge clk);
        #1;
        checkOutput("held_reset");
        rst_n = 1'b1;
        runCycles(FP + 5, 1'b1, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
